// File: rtl/gc_multi.sv
// Tracks up to NUM_SLOTS outstanding lbufs. It counts completion DWs per slot and
// issues gc updates in acceptance order, each held until acknowledged.
module gc_multi #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2,
  parameter int LEN_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_lbuf,
  input  logic [63:0]       lbuf_addr,
  input  logic [LEN_W-1:0]  lbuf_len,
  output logic              wt_lbuf,
  output logic [SLOT_W-1:0] lbuf_slot,
  input  logic              cpl_rcved,
  input  logic [9:0]        cpl_dws,
  input  logic [SLOT_W-1:0] cpl_slot,
  output logic [63:0]       gc_addr,
  output logic              gc_updt,
  input  logic              gc_updt_ack,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, UPDT, GAP} state_t;

  state_t state, state_nxt;

  logic [63:0]          slot_addr [NUM_SLOTS];
  logic [LEN_W-1:0]     slot_len  [NUM_SLOTS];
  logic [LEN_W:0]       dw_cnt    [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid;
  logic [NUM_SLOTS-1:0] done_p1;
  logic [NUM_SLOTS-1:0] over;

  logic [SLOT_W-1:0] wr_ptr, rd_ptr;
  logic [SLOT_W:0]   count, count_nxt;

  logic        accept, free, cpl_to_new, cpl_ok, head_rdy;
  logic        gc_updt_nxt;
  logic [63:0] gc_addr_nxt;
  logic [LEN_W:0] cpl_ext;

  assign accept     = rd_lbuf && !wt_lbuf;
  assign free       = (state == UPDT) && gc_updt_ack;
  // A completion aimed at the slot being filled this cycle lands on the new lbuf.
  assign cpl_to_new = cpl_rcved && accept && (cpl_slot == wr_ptr);
  assign cpl_ok     = cpl_rcved && (valid[cpl_slot] || cpl_to_new);
  assign cpl_ext    = (LEN_W+1)'(cpl_dws);
  assign head_rdy   = valid[rd_ptr] && done_p1[rd_ptr];
  assign lbuf_slot  = wr_ptr;

  always_comb begin
    count_nxt = count;
    if (accept && !free)
      count_nxt = count + (SLOT_W+1)'(1);
    else if (free && !accept)
      count_nxt = count - (SLOT_W+1)'(1);
  end

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++)
      over[i] = valid[i] && (dw_cnt[i] > {slot_len[i], 1'b0});
  end

  // Stage p0: slot payload and DW accumulation
  always_ff @(posedge clk) begin
    if (accept) begin
      slot_addr[wr_ptr] <= lbuf_addr;
      slot_len[wr_ptr]  <= lbuf_len;
    end
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (accept && (wr_ptr == SLOT_W'(i)))
        dw_cnt[i] <= cpl_to_new ? cpl_ext : '0;
      else if (cpl_ok && (cpl_slot == SLOT_W'(i)))
        dw_cnt[i] <= dw_cnt[i] + cpl_ext;
    end
  end

  // Stage p1: queue control, done flags and error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid   <= '0;
      done_p1 <= '0;
      wt_lbuf <= 1'b0;
      err     <= 1'b0;
    end else begin
      count   <= count_nxt;
      wt_lbuf <= (count_nxt == (SLOT_W+1)'(NUM_SLOTS));
      if (accept) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + SLOT_W'(1);
      end
      if (free) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + SLOT_W'(1);
      end
      for (int i = 0; i < NUM_SLOTS; i++)
        done_p1[i] <= valid[i] && (dw_cnt[i] == {slot_len[i], 1'b0}) &&
                      !(free && (rd_ptr == SLOT_W'(i))) &&
                      !(accept && (wr_ptr == SLOT_W'(i)));
      if ((rd_lbuf && wt_lbuf) || (cpl_rcved && !cpl_ok) || (|over))
        err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    gc_updt_nxt = gc_updt;
    gc_addr_nxt = gc_addr;
    case (state)
      IDLE: begin
        if (head_rdy) begin
          state_nxt   = UPDT;
          gc_updt_nxt = 1'b1;
          gc_addr_nxt = slot_addr[rd_ptr] + 64'({slot_len[rd_ptr], 3'b000});
        end
      end
      UPDT: begin
        if (gc_updt_ack) begin
          state_nxt   = GAP;
          gc_updt_nxt = 1'b0;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p2: registered update outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gc_updt <= 1'b0;
      gc_addr <= '0;
    end else begin
      state   <= state_nxt;
      gc_updt <= gc_updt_nxt;
      gc_addr <= gc_addr_nxt;
    end
  end

endmodule

// File: tb/tb_gc_multi.sv
// Scoreboard bench for gc_multi: expected update addresses are queued at acceptance
// and compared in order as the DUT raises gc_updt.
module tb_gc_multi;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;
  localparam int LEN_W     = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rd_lbuf = 1'b0;
  logic [63:0]       lbuf_addr = '0;
  logic [LEN_W-1:0]  lbuf_len = '0;
  logic              wt_lbuf;
  logic [SLOT_W-1:0] lbuf_slot;
  logic              cpl_rcved = 1'b0;
  logic [9:0]        cpl_dws = '0;
  logic [SLOT_W-1:0] cpl_slot = '0;
  logic [63:0]       gc_addr;
  logic              gc_updt;
  logic              gc_updt_ack = 1'b0;
  logic              err;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb [$];

  gc_multi #(.NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .rd_lbuf(rd_lbuf), .lbuf_addr(lbuf_addr), .lbuf_len(lbuf_len),
    .wt_lbuf(wt_lbuf), .lbuf_slot(lbuf_slot), .cpl_rcved(cpl_rcved), .cpl_dws(cpl_dws),
    .cpl_slot(cpl_slot), .gc_addr(gc_addr), .gc_updt(gc_updt), .gc_updt_ack(gc_updt_ack),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rd_lbuf = 1'b0; cpl_rcved = 1'b0; gc_updt_ack = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic accept(input logic [63:0] a, input logic [LEN_W-1:0] l);
    rd_lbuf = 1'b1; lbuf_addr = a; lbuf_len = l;
    @(posedge clk); #1;
    rd_lbuf = 1'b0;
    sb.push_back(a + {29'd0, l, 3'b000});
  endtask

  task automatic cpl(input logic [SLOT_W-1:0] s, input logic [9:0] d);
    cpl_rcved = 1'b1; cpl_slot = s; cpl_dws = d;
    @(posedge clk); #1;
    cpl_rcved = 1'b0;
  endtask

  task automatic wait_updt(input int max_cyc);
    logic [63:0] exp;
    logic seen;
    seen = 1'b0;
    chk("sb_pending", 64'(sb.size() != 0), 64'd1);
    exp = (sb.size() != 0) ? sb.pop_front() : 64'h0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      seen = gc_updt;
    end
    chk("updt_seen", 64'(seen), 64'd1);
    if (seen) begin
      chk("gc_addr", gc_addr, exp);
      @(negedge clk);
      chk("updt_hold", 64'(gc_updt), 64'd1);
      chk("addr_hold", gc_addr, exp);
      gc_updt_ack = 1'b1;
      @(posedge clk); #1;
      gc_updt_ack = 1'b0;
      @(negedge clk);
      chk("updt_gap", 64'(gc_updt), 64'd0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    #2;
    chk("rst_updt", 64'(gc_updt), 64'd0);
    chk("rst_addr", gc_addr, 64'd0);
    chk("rst_wt", 64'(wt_lbuf), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_slot", 64'(lbuf_slot), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single lbuf, two completions, latency and clear on ack
    accept(64'h1000, 32'd4);
    chk("t1_slot", 64'(lbuf_slot), 64'd1);
    cpl(2'd0, 10'd4);
    cpl(2'd0, 10'd4);
    @(negedge clk);
    chk("t1_lat1", 64'(gc_updt), 64'd0);
    @(negedge clk);
    chk("t1_lat2", 64'(gc_updt), 64'd0);
    wait_updt(1);
    chk("t1_err", 64'(err), 64'd0);

    // Out-of-order completions, in-order updates, full flag
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("t2_slot", 64'(lbuf_slot), 64'(i));
      chk("t2_wt_lo", 64'(wt_lbuf), 64'd0);
      accept(64'h2000 + 64'(i) * 64'h1000, 32'd2);
    end
    chk("t2_wt_hi", 64'(wt_lbuf), 64'd1);
    cpl(2'd2, 10'd4);
    cpl(2'd1, 10'd4);
    cpl(2'd3, 10'd4);
    repeat (4) @(negedge clk);
    chk("t2_head_block", 64'(gc_updt), 64'd0);
    cpl(2'd0, 10'd4);
    for (int i = 0; i < 4; i++) wait_updt(10);
    chk("t2_wt_end", 64'(wt_lbuf), 64'd0);
    chk("t2_err", 64'(err), 64'd0);

    // Drop while full, wrap to slot 0 after one ack
    do_reset();
    for (int i = 0; i < 4; i++) accept(64'hA000 + 64'(i) * 64'h100, 32'd1);
    chk("t3_wt", 64'(wt_lbuf), 64'd1);
    chk("t3_slot_wrap", 64'(lbuf_slot), 64'd0);
    rd_lbuf = 1'b1; lbuf_addr = 64'hDEAD_0000; lbuf_len = 32'd1;
    repeat (2) @(posedge clk);
    #1 rd_lbuf = 1'b0;
    @(negedge clk);
    chk("t3_err_drop", 64'(err), 64'd1);
    chk("t3_wt_held", 64'(wt_lbuf), 64'd1);
    cpl(2'd0, 10'd2);
    wait_updt(10);
    chk("t3_wt_fall", 64'(wt_lbuf), 64'd0);
    chk("t3_slot0", 64'(lbuf_slot), 64'd0);
    accept(64'hB000, 32'd3);
    chk("t3_slot1", 64'(lbuf_slot), 64'd1);
    chk("t3_wt_refull", 64'(wt_lbuf), 64'd1);

    // Zero-length lbuf and 64-bit address wrap
    do_reset();
    accept(64'h7777_0000_1234_5678, 32'd0);
    wait_updt(10);
    accept(64'hFFFF_FFFF_FFFF_FFF8, 32'd2);
    cpl(2'd1, 10'd4);
    wait_updt(10);
    chk("t4_err", 64'(err), 64'd0);

    // Error cases: completion to empty slot, overflow blocks the queue
    do_reset();
    cpl(2'd3, 10'd2);
    @(negedge clk);
    chk("t5_err_invalid", 64'(err), 64'd1);
    do_reset();
    @(negedge clk);
    chk("t5_err_cleared", 64'(err), 64'd0);
    accept(64'h100, 32'd2);
    accept(64'h200, 32'd1);
    cpl(2'd0, 10'd6);
    @(negedge clk);
    @(negedge clk);
    chk("t5_err_over", 64'(err), 64'd1);
    cpl(2'd1, 10'd2);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (gc_updt) seen = 1'b1;
    end
    chk("t5_blocked", 64'(seen), 64'd0);

    // Asynchronous reset while an update is pending
    do_reset();
    accept(64'h5000, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = gc_updt;
    end
    chk("t6_pre_updt", 64'(seen), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_updt", 64'(gc_updt), 64'd0);
    chk("t6_addr", gc_addr, 64'd0);
    chk("t6_wt", 64'(wt_lbuf), 64'd0);
    chk("t6_slot", 64'(lbuf_slot), 64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (gc_updt) seen = 1'b1;
    end
    chk("t6_no_updt", 64'(seen), 64'd0);
    accept(64'h6000, 32'd1);
    cpl(2'd0, 10'd2);
    wait_updt(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
